spike_event_encoder: RTL
========================

// Module: spike_event_encoder
// PURPOSE
//  Output-side consumer of the neuron matrix spike interface. Buffers tile spike words
//  {valid, tile address, size_tile-bit spike vector} in a FIFO, then serializes each word
//  into single-neuron address events on a valid/ready stream. The matrix has no
//  backpressure, so overflow is detected and flagged, never stalled. Sits between the
//  neuron matrix and the spike router/output port.
// PARAMETERS
//  size_tile        4                   neurons per tile = spike vector width; power of 2, >=2
//  size_matrix      16                  tiles per matrix
//  size_addr_matrix $clog2(size_matrix) tile address width
//  fifo_depth       4                   tile-word FIFO entries; power of 2, >=2
//  size_count       16                  spike counter width (SPIKE_COUNT_EN only)
// PORTS
//  clk              in  1    clock, rising edge
//  reset            in  1    asynchronous active-low reset (0 = reset)
//  clear            in  1    sync flush: empties FIFO and serializer, clears overflow
//  in_spikeValid    in  1    tile spike word present this cycle
//  in_spike         in  size_tile  spike vector; bit i = neuron i of tile
//  in_spikeAddress  in  size_addr_matrix  tile address
//  out_ready        in  1    downstream accepts event
//  out_valid        out 1    event available
//  out_neuronAddr   out size_addr_matrix+$clog2(size_tile)  {tile addr, bit index}
//  busy             out 1    FIFO non-empty or serializer holds bits
//  overflow         out 1    sticky: a non-zero word was dropped
//  out_spikeCount   out size_count  events handed off (SPIKE_COUNT_EN only)
// BEHAVIOUR
//  Reset (async, reset=0): FIFO empty, serializer idle; out_valid=0, out_neuronAddr=0,
//   busy=0, overflow=0, out_spikeCount=0. Release is synchronous to clk.
//  Push: word written when in_spikeValid=1 and in_spike!=0. Zero vectors are discarded,
//   do not set overflow. Full FIFO: push accepted only if a pop occurs the same cycle;
//   otherwise word dropped, overflow<=1. FIFO order strict.
//  Serializer states: IDLE (no word) / EMIT (mask!=0, tile addr registered).
//   IDLE -> EMIT: FIFO non-empty; pop into mask/addr at next edge.
//   EMIT: out_valid=1; out_neuronAddr={addr, index of lowest set mask bit}
//   (combinational from registers).
//   out_valid & out_ready: clear that bit. If mask then 0: FIFO non-empty -> pop next word
//   same edge (no bubble); else -> IDLE.
//   out_valid=1 & out_ready=0: out_neuronAddr held stable; out_valid never drops without
//   a handshake, except clear or reset.
//  Latency: idle block, word at cycle t -> in FIFO after edge t; popped at edge t+1;
//   out_valid=1 in cycle t+2. Throughput: 1 event/cycle with out_ready=1.
//  Capacity: fifo_depth words + 1 word in serializer.
//  clear beats push in the same cycle: word is discarded. clear does not reset
//   out_spikeCount.
//  busy = FIFO non-empty | (state==EMIT).
// CONFIGURATION
//  SPIKE_COUNT_EN defined: out_spikeCount increments by 1 on each out_valid&out_ready;
//   wraps at 2^size_count; cleared only by reset.
//  SPIKE_COUNT_EN undefined: out_spikeCount port and counter absent.
//  No other behaviour differs.
// TESTING (size_tile=4, size_matrix=16, fifo_depth=4)
//  1 Idle block, out_ready=1; one cycle with valid, addr=3, spike=4'b1010
//    -> out_valid at t+2; events 13 then 15 on consecutive cycles; then out_valid=0, busy=0.
//  2 As 1, out_ready=0 for 5 cycles
//    -> out_valid=1, out_neuronAddr=13 held all 5 cycles; then 13, 15 as out_ready rises.
//  3 out_ready=0; 7 consecutive words, addr=0..6, spike=4'b0001
//    -> overflow=1 after 6th word; release ready -> events 0,4,8,12,16; addr 5,6 never emitted.
//  4 valid=1, spike=4'b0000 for 10 cycles
//    -> no events, busy=0, overflow=0.
//  5 Words addr=2/4'b1111 and addr=9/4'b0110 back-to-back, out_ready=1
//    -> 8,9,10,11,37,38 with no idle cycle between 11 and 37.
//    Repeat, asserting reset=0 after event 9 -> out_valid=0 immediately; after release,
//    busy=0 and no stale events.
//  6 SPIKE_COUNT_EN: run 5 then clear
//    -> out_spikeCount=6; unchanged by clear; reset -> 0.
//    With the macro undefined: same event sequence, port absent.

Source files
------------

// File: rtl/spike_event_encoder.sv
// Buffers tile spike words in a FIFO and serializes each into single-neuron address events.
// Optional `SPIKE_COUNT_EN adds a free-running handshake counter on out_spikeCount.
module spike_event_encoder #(
  parameter int size_tile        = 4,
  parameter int size_matrix      = 16,
  parameter int size_addr_matrix = $clog2(size_matrix),
  parameter int fifo_depth       = 4
`ifdef SPIKE_COUNT_EN
  , parameter int size_count     = 16
`endif
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        clear,
  input  logic                                        in_spikeValid,
  input  logic [size_tile-1:0]                        in_spike,
  input  logic [size_addr_matrix-1:0]                 in_spikeAddress,
  input  logic                                        out_ready,
  output logic                                        out_valid,
  output logic [size_addr_matrix+$clog2(size_tile)-1:0] out_neuronAddr,
  output logic                                        busy,
  output logic                                        overflow
`ifdef SPIKE_COUNT_EN
  , output logic [size_count-1:0]                     out_spikeCount
`endif
);

  localparam int idx_w = $clog2(size_tile);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [size_tile-1:0] one_tile = 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                      state_q, next_state;
  logic [size_tile-1:0]        mem_vec  [fifo_depth];
  logic [size_addr_matrix-1:0] mem_addr [fifo_depth];
  logic [ptr_w-1:0]            wr_q, rd_q;
  logic [cnt_w-1:0]            cnt_q;
  logic [size_tile-1:0]        mask_q, mask_rest;
  logic [size_addr_matrix-1:0] addr_q;
  logic [idx_w-1:0]            bit_idx;
  logic                        fifo_empty, fifo_full;
  logic                        push_req, push, pop, load, shift;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == cnt_w'(fifo_depth));
  assign push_req   = in_spikeValid & (|in_spike) & ~clear;
  assign push       = push_req & (~fifo_full | pop);
  assign mask_rest  = mask_q & (mask_q - one_tile);

  assign out_valid      = (state_q == EMIT);
  assign out_neuronAddr = out_valid ? {addr_q, bit_idx} : '0;
  assign busy           = ~fifo_empty | (state_q == EMIT);

  // Priority pick of the lowest pending neuron in the held word
  always_comb begin
    bit_idx = '0;
    for (int i = size_tile - 1; i >= 0; i--) begin
      if (mask_q[i]) bit_idx = idx_w'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // A finished word is replaced by the FIFO head on the same edge, so there is no bubble
  always_comb begin
    next_state = state_q;
    pop        = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          next_state = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (mask_rest == '0) begin
            if (!fifo_empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              next_state = IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (clear) begin
      next_state = IDLE;
      pop        = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      addr_q <= '0;
    end else if (load) begin
      mask_q <= mem_vec[rd_q];
      addr_q <= mem_addr[rd_q];
    end else if (shift) begin
      mask_q <= mask_rest;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_vec[wr_q]  <= in_spike;
      mem_addr[wr_q] <= in_spikeAddress;
    end
  end

  // The matrix cannot be stalled, so a word arriving at a full FIFO is lost and flagged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + ptr_w'(1);
      if (pop)  rd_q <= rd_q + ptr_w'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + cnt_w'(1);
        2'b01:   cnt_q <= cnt_q - cnt_w'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     out_spikeCount <= '0;
    else if (out_valid && out_ready) out_spikeCount <= out_spikeCount + size_count'(1);
  end
`endif

endmodule
